// File: rtl/aes_out_serializer.sv
// Byte serializer for AES cipher blocks: buffers up to two blocks and streams
// them MSB byte first over a valid/ready byte interface.
module aes_out_serializer #(
  parameter int DATA_LEN = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                data_valid_in,
  input  logic [DATA_LEN-1:0] cipher_text,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic [7:0]          byte_data,
  output logic                byte_last,
  output logic                busy,
  output logic                overflow
);
  localparam int NB = DATA_LEN / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              r_state, w_state_next;
  logic [1:0]          r_occ, w_occ_next;
  logic [DATA_LEN-1:0] r_head, w_head_next;
  logic [DATA_LEN-1:0] r_tail, w_tail_next;
  logic [CW-1:0]       r_cnt, w_cnt_next;
  logic                r_overflow, w_ovf_next;

  logic                w_xfer, w_pop, w_push;
  logic [7:0]          w_bytes [NB];

  // Byte 0 is the most significant byte of the block.
  for (genvar gi = 0; gi < NB; gi++) begin : g_bytes
    assign w_bytes[gi] = r_head[DATA_LEN-1-8*gi -: 8];
  end

  assign byte_valid = (r_occ != 2'd0);
  assign busy       = (r_occ != 2'd0);
  assign byte_last  = byte_valid && (r_cnt == CW'(NB-1));
  assign byte_data  = w_bytes[r_cnt];
  assign overflow   = r_overflow;

  assign w_xfer = byte_valid && byte_ready;
  assign w_pop  = w_xfer && (r_cnt == CW'(NB-1));
  assign w_push = data_valid_in && ((r_occ < 2'd2) || w_pop);

  always_comb begin
    w_state_next = r_state;
    w_occ_next   = r_occ;
    w_head_next  = r_head;
    w_tail_next  = r_tail;
    w_cnt_next   = r_cnt;
    w_ovf_next   = r_overflow;

    if (w_pop) begin
      w_cnt_next  = '0;
      w_head_next = r_tail;
      w_occ_next  = r_occ - 2'd1;
    end else if (w_xfer) begin
      w_cnt_next = r_cnt + CW'(1);
    end

    // The new block lands behind whatever survives this edge's pop.
    if (w_push) begin
      if (w_occ_next == 2'd0) w_head_next = cipher_text;
      else                    w_tail_next = cipher_text;
      w_occ_next = w_occ_next + 2'd1;
    end else if (data_valid_in) begin
      w_ovf_next = 1'b1;
    end

    case (r_state)
      IDLE:    if (w_push) w_state_next = SEND;
      SEND:    if (w_pop && (w_occ_next == 2'd0)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_occ      <= 2'd0;
      r_head     <= '0;
      r_tail     <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_occ      <= w_occ_next;
      r_head     <= w_head_next;
      r_tail     <= w_tail_next;
      r_cnt      <= w_cnt_next;
      r_overflow <= w_ovf_next;
    end
  end
endmodule

// File: tb/tb_aes_out_serializer.sv
// Self-checking bench for aes_out_serializer: directed scenarios plus random
// traffic, compared against a block-queue reference model.
module tb_aes_out_serializer;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         data_valid_in = 1'b0;
  logic [127:0] cipher_text = '0;
  logic         byte_valid;
  logic         byte_ready = 1'b0;
  logic [7:0]   byte_data;
  logic         byte_last;
  logic         busy;
  logic         overflow;

  aes_out_serializer #(.DATA_LEN(128)) dut (
    .clk(clk), .reset(reset), .data_valid_in(data_valid_in),
    .cipher_text(cipher_text), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .byte_data(byte_data), .byte_last(byte_last),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of whole blocks, byte index into the head, sticky flag.
  logic [127:0] m_q[$];
  int           m_cnt = 0;
  bit           m_ovf = 1'b0;

  localparam logic [127:0] BLK_A = 128'h0336763e966d92595a567cc9ce537f5e;
  localparam logic [127:0] BLK_B = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BLK_C = 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] m_byte();
    logic [127:0] blk;
    blk = m_q[0];
    return 8'((blk >> (8 * (15 - m_cnt))) & 128'hff);
  endfunction

  task automatic check_outputs(input string tag);
    bit v;
    v = (m_q.size() > 0);
    chk({tag, ".valid"}, 32'(byte_valid), 32'(v));
    chk({tag, ".busy"},  32'(busy),       32'(v));
    chk({tag, ".last"},  32'(byte_last),  32'(v && m_cnt == 15));
    chk({tag, ".ovf"},   32'(overflow),   32'(m_ovf));
    if (v) chk({tag, ".data"}, 32'(byte_data), 32'(m_byte()));
  endtask

  // Called at a falling edge: drive, take one rising edge, update model, check.
  task automatic cycle(input string tag, input bit dv, input logic [127:0] ct, input bit rdy);
    bit pop;
    bit can_push;
    data_valid_in = dv;
    cipher_text   = ct;
    byte_ready    = rdy;
    @(posedge clk);
    pop = 1'b0;
    can_push = (m_q.size() < 2);
    if (m_q.size() > 0 && rdy) begin
      if (m_cnt == 15) begin
        pop = 1'b1;
        void'(m_q.pop_front());
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    if (dv) begin
      if (can_push || pop) m_q.push_back(ct);
      else m_ovf = 1'b1;
    end
    @(negedge clk);
    data_valid_in = 1'b0;
    check_outputs(tag);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, ".rst_valid"}, 32'(byte_valid), 32'd0);
    chk({tag, ".rst_busy"},  32'(busy),       32'd0);
    chk({tag, ".rst_last"},  32'(byte_last),  32'd0);
    chk({tag, ".rst_ovf"},   32'(overflow),   32'd0);
    chk({tag, ".rst_data"},  32'(byte_data),  32'd0);
    m_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    byte_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset.valid", 32'(byte_valid), 32'd0);
    chk("reset.busy",  32'(busy),       32'd0);
    chk("reset.ovf",   32'(overflow),   32'd0);
    chk("reset.data",  32'(byte_data),  32'd0);
    reset = 1'b0;

    // Single block, ready high; first push on first edge after reset.
    cycle("single", 1'b1, BLK_A, 1'b1);
    chk("single.first", 32'(byte_data), 32'h03);
    for (int i = 0; i < 17; i++) cycle("single", 1'b0, '0, 1'b1);

    // Backpressure at cnt=4 for three cycles.
    cycle("bp", 1'b1, BLK_A, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle("bp", 1'b0, '0, !(i >= 4 && i <= 6));
      if (i >= 4 && i <= 6) chk("bp.hold", 32'(byte_data), 32'h96);
    end

    // Back-to-back blocks.
    cycle("b2b", 1'b1, BLK_A, 1'b1);
    cycle("b2b", 1'b1, BLK_B, 1'b1);
    for (int i = 0; i < 33; i++) cycle("b2b", 1'b0, '0, 1'b1);

    // Overflow: third block dropped while stalled.
    cycle("ovf", 1'b1, BLK_A, 1'b0);
    cycle("ovf", 1'b1, BLK_B, 1'b0);
    cycle("ovf", 1'b1, BLK_C, 1'b0);
    chk("ovf.flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 34; i++) cycle("ovf", 1'b0, '0, 1'b1);
    chk("ovf.sticky", 32'(overflow), 32'd1);
    do_reset("ovf");

    // Push on the pop edge with a full FIFO.
    cycle("pushpop", 1'b1, BLK_A, 1'b0);
    cycle("pushpop", 1'b1, BLK_B, 1'b0);
    for (int i = 0; i < 15; i++) cycle("pushpop", 1'b0, '0, 1'b1);
    cycle("pushpop", 1'b1, BLK_C, 1'b1);
    chk("pushpop.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 33; i++) cycle("pushpop", 1'b0, '0, 1'b1);

    // Reset mid-block at cnt=7, then a fresh block starts at byte 0.
    cycle("midrst", 1'b1, BLK_B, 1'b1);
    for (int i = 0; i < 7; i++) cycle("midrst", 1'b0, '0, 1'b1);
    do_reset("midrst");
    cycle("midrst", 1'b1, BLK_A, 1'b1);
    chk("midrst.first", 32'(byte_data), 32'h03);
    for (int i = 0; i < 16; i++) cycle("midrst", 1'b0, '0, 1'b1);

    // Random traffic in phases of varying pressure.
    for (int ph = 0; ph < 8; ph++) begin
      int dv_pct;
      int rdy_pct;
      dv_pct  = (ph % 2 == 0) ? 8 : 30;
      rdy_pct = (ph % 3 == 0) ? 40 : 90;
      for (int i = 0; i < 150; i++) begin
        logic [127:0] blk;
        blk = {$urandom, $urandom, $urandom, $urandom};
        cycle("rand", ($urandom_range(0, 99) < dv_pct),
              blk, ($urandom_range(0, 99) < rdy_pct));
      end
      if (ph == 3) do_reset("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/aes_out_serializer.md
AES_OUT_SERIALIZER -- requirements
Module: aes_out_serializer

Interface
REQ-001 The block SHALL have parameter DATA_LEN, default 128: width of one cipher block; SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter NB, default DATA_LEN/8: number of bytes per block (derived, not overridden).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state SHALL update on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port data_valid_in, input, 1 bit: one-cycle strobe from the AES core's data_valid_out.
REQ-006 The block SHALL have port cipher_text, input, DATA_LEN bits: block from the AES core; sampled only when data_valid_in=1.
REQ-007 The block SHALL have port byte_valid, output, 1 bit: byte_data holds a valid byte.
REQ-008 The block SHALL have port byte_ready, input, 1 bit: downstream accepts a byte.
REQ-009 The block SHALL have port byte_data, output, 8 bits: current byte.
REQ-010 The block SHALL have port byte_last, output, 1 bit: current byte is byte NB-1 of its block.
REQ-011 The block SHALL have port busy, output, 1 bit: at least one block is buffered.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag set when a block has been dropped.

Function
REQ-013 Storage SHALL be a 2-entry block FIFO: occupancy 0..2, head entry, tail entry, and a byte counter cnt of range 0..NB-1.
REQ-014 States SHALL be IDLE (occupancy=0) and SEND (occupancy>0).
REQ-015 IDLE->SEND SHALL occur on a push.
REQ-016 SEND->IDLE SHALL occur on a pop that leaves occupancy=0.
REQ-017 A transfer SHALL be defined as byte_valid=1 and byte_ready=1 on the same rising edge.
REQ-018 byte_valid SHALL equal (occupancy>0).
REQ-019 byte_data SHALL equal head[DATA_LEN-1-8*cnt -: 8], so the MSB byte is sent first.
REQ-020 byte_last SHALL equal byte_valid and (cnt=NB-1).
REQ-021 busy SHALL equal (occupancy>0).
REQ-022 Output latency: a block pushed into an empty FIFO at edge k SHALL drive byte_valid=1 with byte 0 after edge k.
REQ-023 There SHALL be no combinational path from data_valid_in or cipher_text to any output.
REQ-024 Each transfer with cnt<NB-1 SHALL increment cnt.
REQ-025 A transfer with cnt=NB-1 SHALL pop the head, reset cnt to 0 and promote the tail to head.
REQ-026 After a pop that leaves a block queued, that block's byte 0 SHALL be presented on the next cycle with no bubble.
REQ-027 While byte_valid=1 and byte_ready=0, byte_data and byte_last SHALL hold stable.
REQ-028 A push SHALL occur when data_valid_in=1 and either occupancy<2 or a pop occurs on the same edge.
REQ-029 On a simultaneous push and pop, the occupancy SHALL stay unchanged and the new block SHALL enter behind the remaining entry.
REQ-030 When data_valid_in=1, occupancy=2 and there is no pop, the block SHALL be discarded, FIFO contents SHALL be unaffected, and overflow SHALL be set to 1.
REQ-031 overflow SHALL be cleared only by reset.
REQ-032 byte_ready SHALL be ignored while byte_valid=0.
REQ-033 data_valid_in held high for multiple cycles SHALL be treated as one push per cycle.

Reset
REQ-034 While reset=1, the block SHALL asynchronously force occupancy=0, cnt=0, IDLE, byte_valid=0, byte_last=0, busy=0, overflow=0 and byte_data=8'h00.
REQ-035 Reset asserted mid-block SHALL abandon all buffered data with no partial-block resume.
REQ-036 The first push SHALL be accepted on the first rising edge after reset deassertion.

Verification
REQ-037 Scenario: single block with ready tied high.
- Stimulus: push 0336763e966d92595a567cc9ce537f5e.
- Response: 16 consecutive transfers 03,36,76,...,5e; byte_last only on 5e; busy falls the cycle after.
REQ-038 Scenario: backpressure.
- Stimulus: same block; byte_ready low for 3 cycles at cnt=4.
- Response: byte_data holds 96 for those cycles; sequence otherwise identical.
REQ-039 Scenario: back-to-back blocks.
- Stimulus: push A=0336...5e then B=00112233445566778899aabbccddeeff one cycle apart; ready high.
- Response: 32 contiguous transfers; 00 follows 5e with no gap; overflow=0.
REQ-040 Scenario: overflow.
- Stimulus: ready low; push three blocks.
- Response: third block dropped; overflow=1 and sticky; after ready rises, only blocks 1 and 2 are emitted.
REQ-041 Scenario: push on pop edge.
- Stimulus: occupancy=2; push C on the edge of block 1's last transfer.
- Response: C accepted; overflow stays 0; output order is 1, 2, C.
REQ-042 Scenario: reset mid-block.
- Stimulus: assert reset asynchronously at cnt=7.
- Response: all outputs go to 0 immediately; the next pushed block starts at byte 0.
